// File: rtl/mvm_seq_pkg.sv
// mvm_seq_pkg: shared widths, TUSER layout, FSM states and command-entry type for the stream sequencer
package mvm_seq_pkg;
  localparam int DATAW = 512;
  localparam int IDW = 32;
  localparam int DESTW = 12;
  localparam int USERW = 75;
  localparam int CMD_DEPTH = 16;
  localparam int CMD_AW = $clog2(CMD_DEPTH);
  localparam int RF_LSB = 0;
  localparam int KIND_LSB = 9;
  localparam int PAD_LSB = 11;
  typedef enum logic [1:0] {KIND_INST = 2'b00, KIND_VEC = 2'b10} kind_e;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, DONE_S, ERR} state_e;
  typedef struct packed {
    logic [DATAW-1:0] data;
    logic [DESTW-1:0] dest;
    logic [1:0] kind;
    logic [8:0] rfaddr;
  } cmd_t;
  function automatic logic [USERW-1:0] pack_tuser(input cmd_t c);
    logic [USERW-1:0] t;
    t[USERW-1:PAD_LSB] = '0;
    t[KIND_LSB +: 2] = c.kind;
    t[RF_LSB +: 9] = c.rfaddr;
    return t;
  endfunction
endpackage

// File: rtl/mvm_stream_sequencer_if.sv
// mvm_stream_sequencer_if: AXIS link to mvm_top; s_* = flits into mvm_top AXIS_S, m_* = results from mvm_top AXIS_M
interface mvm_stream_sequencer_if;
  import mvm_seq_pkg::*;
  logic s_tvalid;
  logic s_tready;
  logic s_tlast;
  logic [DATAW-1:0] s_tdata;
  logic [IDW-1:0] s_tid;
  logic [USERW-1:0] s_tuser;
  logic [DESTW-1:0] s_tdest;
  logic m_tvalid;
  logic m_tlast;
  logic m_tready;
  modport master (
    output s_tvalid, s_tlast, s_tdata, s_tid, s_tuser, s_tdest, m_tready,
    input s_tready, m_tvalid, m_tlast
  );
  modport slave (
    input s_tvalid, s_tlast, s_tdata, s_tid, s_tuser, s_tdest, m_tready,
    output s_tready, m_tvalid, m_tlast
  );
endinterface

// File: rtl/mvm_seq_cmd_table.sv
// mvm_seq_cmd_table: CMD_DEPTH-entry command register file; ports clk, we/wa/wd write port, ra/rd combinational read
module mvm_seq_cmd_table
  import mvm_seq_pkg::*;
(
  input  logic clk,
  input  logic we,
  input  logic [CMD_AW-1:0] wa,
  input  cmd_t wd,
  input  logic [CMD_AW-1:0] ra,
  output cmd_t rd
);
  cmd_t mem [CMD_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/mvm_stream_sequencer.sv
// mvm_stream_sequencer: issues a command table as AXIS flits to mvm_top, then counts result packets until expected count or timeout
// Ports: clk, rst_n (async active-low); cmd_wr_* table write port; cmd_count/exp_results/start run control;
// axis (master modport: s_* flit output, m_* result input); busy/done/timeout_err/result_cnt status.
module mvm_stream_sequencer
  import mvm_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_wr_en,
  input  logic [CMD_AW-1:0] cmd_wr_addr,
  input  logic [DATAW-1:0] cmd_wr_data,
  input  logic [DESTW-1:0] cmd_wr_dest,
  input  logic [1:0] cmd_wr_kind,
  input  logic [8:0] cmd_wr_rfaddr,
  input  logic [CMD_AW:0] cmd_count,
  input  logic [15:0] exp_results,
  input  logic start,
  mvm_stream_sequencer_if.master axis,
  output logic busy,
  output logic done,
  output logic timeout_err,
  output logic [15:0] result_cnt
);
  localparam int TOW = $clog2(TIMEOUT_CYC);
  state_e state, nxt;
  logic [CMD_AW-1:0] idx, rd_addr;
  logic [CMD_AW:0] cnt_q;
  logic [15:0] exp_q;
  logic [TOW-1:0] to_cnt;
  logic launch, hs, last, result;
  cmd_t rd;
  assign busy = state == ISSUE || state == WAIT_RESP;
  assign done = state == DONE_S;
  assign timeout_err = state == ERR;
  assign launch = start && !busy;
  assign hs = state == ISSUE && axis.s_tvalid && axis.s_tready;
  assign last = hs && {1'b0, idx} == cnt_q - 1'b1;
  assign result = axis.m_tvalid && axis.m_tready && axis.m_tlast;
  // Entry 0 is fetched at START so it is on the bus the very next cycle; afterwards the successor is prefetched on each handshake.
  assign rd_addr = launch ? '0 : idx + 1'b1;
  assign axis.s_tid = '0;
  assign axis.s_tlast = axis.s_tvalid;
  mvm_seq_cmd_table u_tbl (
    .clk(clk),
    .we(cmd_wr_en && !busy),
    .wa(cmd_wr_addr),
    .wd('{data: cmd_wr_data, dest: cmd_wr_dest, kind: cmd_wr_kind, rfaddr: cmd_wr_rfaddr}),
    .ra(rd_addr),
    .rd(rd)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      ISSUE: nxt = last ? WAIT_RESP : ISSUE;
      WAIT_RESP: nxt = result_cnt >= exp_q ? DONE_S
                     : (!result && to_cnt == TOW'(TIMEOUT_CYC - 1)) ? ERR : WAIT_RESP;
      default: nxt = launch ? (cmd_count != '0 ? ISSUE : WAIT_RESP) : state;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      axis.s_tvalid <= 1'b0;
      axis.s_tdata <= '0;
      axis.s_tdest <= '0;
      axis.s_tuser <= '0;
      axis.m_tready <= 1'b0;
      idx <= '0;
      cnt_q <= '0;
      exp_q <= '0;
      to_cnt <= '0;
      result_cnt <= '0;
    end else begin
      axis.m_tready <= 1'b1;
      to_cnt <= (state == WAIT_RESP && !result) ? to_cnt + 1'b1 : '0;
      if (launch) begin
        idx <= '0;
        cnt_q <= cmd_count;
        exp_q <= exp_results;
        result_cnt <= '0;
        axis.s_tvalid <= cmd_count != '0;
        axis.s_tdata <= rd.data;
        axis.s_tdest <= rd.dest;
        axis.s_tuser <= pack_tuser(rd);
      end else begin
        if (busy && result && result_cnt != 16'hFFFF) result_cnt <= result_cnt + 1'b1;
        if (last) axis.s_tvalid <= 1'b0;
        else if (hs) begin
          idx <= idx + 1'b1;
          axis.s_tdata <= rd.data;
          axis.s_tdest <= rd.dest;
          axis.s_tuser <= pack_tuser(rd);
        end
      end
    end
endmodule
